// File: rtl/mem_region_decode_if.sv
// rtl/mem_region_decode_if.sv - request/response bundle between a CPU memory port and mem_region_decode
// Signals:
//   req      master->slave  access request, sampled only while busy=0
//   wr       master->slave  1=write, 0=read, sampled with req
//   addr     master->slave  access address, sampled with req
//   busy     slave->master  high while an access is in progress
//   sel      slave->master  one-hot region select, all zero when idle
//   ack      slave->master  one-cycle pulse on the final select cycle
//   err      slave->master  one-cycle pulse for a faulted access
//   hit_idx  slave->master  index of the active (or offending) region
interface mem_region_decode_if #(
  parameter int ADDR_W  = 13,
  parameter int NUM_REG = 2
);
  logic               req;
  logic               wr;
  logic [ADDR_W-1:0]  addr;
  logic               busy;
  logic [NUM_REG-1:0] sel;
  logic               ack;
  logic               err;
  logic [2:0]         hit_idx;

  modport master (
    output req, wr, addr,
    input  busy, sel, ack, err, hit_idx
  );

  modport slave (
    input  req, wr, addr,
    output busy, sel, ack, err, hit_idx
  );
endinterface

// File: rtl/mem_region_decode.sv
// rtl/mem_region_decode.sv - registered base/mask region decoder with per-region wait states
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous, active-high reset
//   bus      mem_region_decode_if.slave: req/wr/addr in; busy/sel/ack/err/hit_idx out
// Optional build macro: WR_PROTECT_EN - writes to regions flagged in REG_RO fault
// instead of selecting; the offending region is reported on hit_idx.
module mem_region_decode #(
  parameter int                        ADDR_W   = 13,
  parameter int                        NUM_REG  = 2,
  parameter int                        WS_W     = 4,
  parameter logic [NUM_REG*ADDR_W-1:0] REG_BASE = {13'h0000, 13'h1800},
  parameter logic [NUM_REG*ADDR_W-1:0] REG_MASK = {13'h0000, 13'h1800},
  parameter logic [NUM_REG*WS_W-1:0]   REG_WS   = {4'd1, 4'd0},
  parameter logic [NUM_REG-1:0]        REG_RO   = 2'b10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mem_region_decode_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic [NUM_REG-1:0] r_sel;
  logic               r_ack;
  logic               r_err;
  logic [2:0]         r_hit_idx;
  logic [WS_W-1:0]    r_cnt;

  logic               w_hit;
  logic [2:0]         w_idx;
  logic [WS_W-1:0]    w_ws;
  logic [NUM_REG-1:0] w_sel;
  logic               w_fault;
`ifdef WR_PROTECT_EN
  logic               w_ro;
`endif

  // Scan from the highest index down so the lowest hitting index is the
  // last assignment and therefore wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_ws  = '0;
    w_sel = '0;
`ifdef WR_PROTECT_EN
    w_ro  = 1'b0;
`endif
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      if ((bus.addr & REG_MASK[i*ADDR_W +: ADDR_W]) ==
          (REG_BASE[i*ADDR_W +: ADDR_W] & REG_MASK[i*ADDR_W +: ADDR_W])) begin
        w_hit    = 1'b1;
        w_idx    = 3'(i);
        w_ws     = REG_WS[i*WS_W +: WS_W];
        w_sel    = '0;
        w_sel[i] = 1'b1;
`ifdef WR_PROTECT_EN
        w_ro     = REG_RO[i];
`endif
      end
    end
  end

`ifdef WR_PROTECT_EN
  assign w_fault = !w_hit || (bus.wr && w_ro);
`else
  assign w_fault = !w_hit;
`endif

  // The request is captured in decoded form (select, index, wait count) at
  // the accepting edge, so later changes on addr/wr cannot affect it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_sel     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_hit_idx <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_sel  <= '0;
          r_ack  <= 1'b0;
          r_err  <= 1'b0;
          if (bus.req) begin
            r_busy <= 1'b1;
            if (w_fault) begin
              r_state <= S_FAULT;
              r_err   <= 1'b1;
`ifdef WR_PROTECT_EN
              if (w_hit) r_hit_idx <= w_idx;
`endif
            end else begin
              r_state   <= S_ACCESS;
              r_sel     <= w_sel;
              r_hit_idx <= w_idx;
              r_cnt     <= w_ws;
              // zero wait states: select and ack share the one cycle
              r_ack     <= (w_ws == '0);
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_ack <= (r_cnt == WS_W'(1));
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
          end
        end
        S_FAULT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_sel   <= '0;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.sel     = r_sel;
  assign bus.ack     = r_ack;
  assign bus.err     = r_err;
  assign bus.hit_idx = r_hit_idx;

endmodule

// File: tb/tb_mem_region_decode.sv
// tb/tb_mem_region_decode.sv - self-checking bench for mem_region_decode (default map and a sparse-mask map)
module tb_mem_region_decode;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int exp_idx [2];

  mem_region_decode_if #(.ADDR_W(13), .NUM_REG(2)) bus0 ();
  mem_region_decode_if #(.ADDR_W(13), .NUM_REG(2)) bus1 ();

  mem_region_decode u_dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus0)
  );

  mem_region_decode #(
    .REG_MASK ({13'h1800, 13'h1800})
  ) u_dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory map from the region table: first matching entry wins, no match
  // is a fault; with write protection a write into a read-only region faults.
  function automatic void model(input int which, input int a, input bit w,
                                output bit fault, output int idx, output int ws);
    int base [2];
    int mask [2];
    int wst  [2];
    bit ro   [2];
    base = '{32'h1800, 32'h0000};
    wst  = '{0, 1};
    ro   = '{1'b0, 1'b1};
    if (which == 0) mask = '{32'h1800, 32'h0000};
    else            mask = '{32'h1800, 32'h1800};
    idx = -1;
    for (int i = 0; i < 2; i++)
      if (idx < 0 && ((a & mask[i]) == (base[i] & mask[i]))) idx = i;
    fault = (idx < 0);
    ws    = fault ? 0 : wst[idx];
`ifdef WR_PROTECT_EN
    if (!fault && w && ro[idx]) fault = 1'b1;
`else
    if (w) ws = ws + 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input bit r, input logic [12:0] a, input bit w);
    if (which == 0) begin bus0.req = r; bus0.addr = a; bus0.wr = w; end
    else            begin bus1.req = r; bus1.addr = a; bus1.wr = w; end
  endtask

  task automatic sample(input int which, output logic busy, output logic [1:0] sel,
                        output logic ack, output logic err, output logic [2:0] hidx);
    if (which == 0) begin
      busy = bus0.busy; sel = bus0.sel; ack = bus0.ack; err = bus0.err; hidx = bus0.hit_idx;
    end else begin
      busy = bus1.busy; sel = bus1.sel; ack = bus1.ack; err = bus1.err; hidx = bus1.hit_idx;
    end
  endtask

  // Request must already be presented; the next rising edge accepts it.
  // With rel=1 the request is dropped and addr/wr are scrambled afterwards.
  task automatic check_access(input int which, input logic [12:0] a, input bit w, input bit rel);
    bit         fault;
    int         idx, ws, len;
    logic       busy, ack, err;
    logic [1:0] sel;
    logic [2:0] hidx;
    model(which, int'(a), w, fault, idx, ws);
    @(posedge clk);
    if (rel) begin
      #1;
      set_req(which, 1'b0, 13'($urandom), 1'($urandom));
    end
    if (idx >= 0) exp_idx[which] = idx;
    len = fault ? 1 : ws + 1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      sample(which, busy, sel, ack, err, hidx);
      chk("busy_active", 32'(busy), 32'd1);
      chk("sel_active",  32'(sel),  fault ? 32'd0 : (32'd1 << idx));
      chk("ack_active",  32'(ack),  32'(!fault && c == len));
      chk("err_active",  32'(err),  32'(fault && c == 1));
      chk("hit_idx",     32'(hidx), 32'(exp_idx[which]));
      chk("ack_err_excl", 32'(ack & err), 32'd0);
    end
    @(negedge clk);
    sample(which, busy, sel, ack, err, hidx);
    chk("busy_done", 32'(busy), 32'd0);
    chk("sel_done",  32'(sel),  32'd0);
    chk("ack_done",  32'(ack),  32'd0);
    chk("err_done",  32'(err),  32'd0);
    chk("hit_idx_held", 32'(hidx), 32'(exp_idx[which]));
  endtask

  task automatic single(input int which, input logic [12:0] a, input bit w);
    set_req(which, 1'b1, a, w);
    check_access(which, a, w, 1'b1);
  endtask

  initial begin
    logic       busy, ack, err;
    logic [1:0] sel;
    logic [2:0] hidx;
    int         which;
    logic [12:0] a;
    bit         w;
    logic [12:0] corner [8];

    exp_idx = '{0, 0};
    rst = 1'b1;
    set_req(0, 1'b0, 13'h0, 1'b0);
    set_req(1, 1'b0, 13'h0, 1'b0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sample(d, busy, sel, ack, err, hidx);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_sel",  32'(sel),  32'd0);
      chk("reset_ack",  32'(ack),  32'd0);
      chk("reset_err",  32'(err),  32'd0);
      chk("reset_idx",  32'(hidx), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // directed accesses from the test plan and priority/miss corners
    single(0, 13'h0100, 1'b0);
    single(0, 13'h1FFF, 1'b0);
    single(0, 13'h1800, 1'b0);
    single(1, 13'h1800, 1'b0);
    single(1, 13'h0900, 1'b0);
    single(1, 13'h0100, 1'b0);
    single(1, 13'h0900, 1'b1);
    single(0, 13'h0100, 1'b1);
    single(0, 13'h0100, 1'b0);
    single(1, 13'h0000, 1'b1);

    // request held high across three back-to-back accesses
    set_req(0, 1'b1, 13'h0100, 1'b0);
    for (int k = 0; k < 3; k++) check_access(0, 13'h0100, 1'b0, 1'b0);
    set_req(0, 1'b0, 13'h0100, 1'b0);
    @(negedge clk);
    sample(0, busy, sel, ack, err, hidx);
    chk("held_release_idle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a wait-state access
    set_req(0, 1'b1, 13'h0100, 1'b0);
    @(posedge clk);
    #1 set_req(0, 1'b0, 13'h0100, 1'b0);
    @(negedge clk);
    sample(0, busy, sel, ack, err, hidx);
    chk("pre_reset_sel", 32'(sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    sample(0, busy, sel, ack, err, hidx);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_sel",  32'(sel),  32'd0);
    chk("async_rst_ack",  32'(ack),  32'd0);
    chk("async_rst_err",  32'(err),  32'd0);
    chk("async_rst_idx",  32'(hidx), 32'd0);
    exp_idx = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    single(0, 13'h0100, 1'b0);

    // randomized accesses, biased towards region edges
    corner = '{13'h0000, 13'h07FF, 13'h0800, 13'h0FFF, 13'h1000, 13'h17FF, 13'h1800, 13'h1FFF};
    for (int n = 0; n < 60; n++) begin
      which = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 7)];
      else                           a = 13'($urandom);
      w = 1'($urandom);
      single(which, a, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
